aclint_timer: RTL and testbench
===============================

Name: aclint_timer

Overview:
Parametrised successor to the single-mode core-local timer/IPI block. Provides a 64-bit mtime counter with a selectable tick source: either a synchronised RTC rising edge or an internal programmable prescaler on clk_i. Provides a per-hart mtimecmp, plus per-hart machine (MSIP) and supervisor (SSIP) software-interrupt bits. Sits behind the peripheral crossbar on a simple req/gnt/rvalid register port that supports 32- or 64-bit data with byte enables.

Parameters:
NR_HARTS, 1, number of harts; sets the count of mtimecmp/msip/ssip entries and of the IRQ output bits (1..4095)
DATA_WIDTH, 64, register-port data width; 32 or 64 only
PRESCALE_W, 16, width of the prescaler reload register
SYNC_STAGES, 2, synchroniser depth for rtc_i (>=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  register access request
we_i  in  1  1=write, 0=read
addr_i  in  16  byte offset within block
wdata_i  in  DATA_WIDTH  write data
be_i  in  DATA_WIDTH/8  byte enables
gnt_o  out  1  grant; always equals req_i (no backpressure)
rvalid_o  out  1  response valid, one cycle after an accepted req
rdata_o  out  DATA_WIDTH  read data, valid with rvalid_o (0 for writes and errors)
err_o  out  1  error response, valid with rvalid_o
rtc_i  in  1  asynchronous real-time clock
timer_irq_o  out  NR_HARTS  machine timer interrupt, registered
msip_o  out  NR_HARTS  machine software interrupt
ssip_o  out  NR_HARTS  supervisor software interrupt

Behaviour:
- Reset is rst_ni, asynchronous, active-low; clock is clk_i.
- Reset values: mtime=0; mtimecmp[h]=all-ones; msip=ssip=0; CTRL=0x2 (enable=1, src=RTC); PRESCALE=0; prescaler count=0. Outputs after reset: rvalid_o/err_o/rdata_o/timer_irq_o/msip_o/ssip_o=0.
- Register map:
  - MSIP[h] at 0x0000+4h, bit0.
  - MTIMECMP[h] at 0x4000+8h.
  - MTIME at 0xBFF8.
  - SSIP[h] at 0xC000+4h, bit0.
  - CTRL at 0xD000: bit0 src (0=RTC edge, 1=prescaler), bit1 enable.
  - PRESCALE at 0xD004.
- All registers are naturally aligned. On a 64-bit port, a 32-bit register occupies lanes selected by addr_i[2]. On a 32-bit port, 64-bit registers are accessed as two words at +0 (low) and +4 (high).
- Writes are byte-enable masked; only enabled bytes change.
- Errors: hart index >= NR_HARTS, unmapped offset, or misaligned addr_i[1:0]!=0 -> err_o=1 with rvalid_o, no state change, rdata_o=0.
- Latency: the access is accepted the same cycle as req_i. rvalid_o/rdata_o/err_o are registered and appear the next cycle. Back-to-back accesses are supported every cycle.
- Tick generation:
  - src=0: rtc_i passes through an SYNC_STAGES synchroniser plus edge detect; a rising edge produces a one-cycle tick.
  - src=1: the down-counter reloads to PRESCALE when it reaches 0 and emits a tick, giving a period of PRESCALE+1 cycles (PRESCALE=0 -> tick every cycle).
  - A write to PRESCALE or CTRL resets the counter to the new PRESCALE value.
  - enable=0 suppresses ticks; the synchroniser and counter keep running.
- On tick, mtime increments by 1 and wraps modulo 2^64 (all-ones -> 0).
- A bus write to any mtime byte in the same cycle as a tick wins: the written bytes take wdata, and unwritten bytes keep their old value with no increment.
- timer_irq_o[h] is registered from (mtime_q >= mtimecmp_q[h]), unsigned 64-bit compare, so it lags a register change by one cycle. It stays asserted until the compare fails.
- msip_o/ssip_o drive directly from the register bits.
- Reads return the current registered values. Unused bits read 0.

Decomposition:
- aclint_pkg holds: the offset constants (MSIP_BASE, MTIMECMP_BASE, MTIME_BASE, SSIP_BASE, CTRL_OFF, PRESCALE_OFF), the CTRL bit positions, and a ctrl_t packed struct.
- One sub-module, aclint_tick_gen: RTC synchroniser/edge detector plus prescaler. Inputs are src, enable, prescale and reload; output is tick_o.

Test Plan:
- Reset check: after reset, read MTIMECMP[0] -> 0xFFFF_FFFF_FFFF_FFFF; CTRL -> 0x2; timer_irq_o=0; mtime stays 0 with rtc_i idle.
- RTC mode: toggle rtc_i 5 full periods -> MTIME reads 5. rtc_i high for 20 cycles -> exactly one increment.
- Prescaler mode: write PRESCALE=3 then CTRL=0x3, wait 40 cycles -> mtime increments every 4 cycles (10 ±1). Write CTRL=0x1 -> mtime frozen.
- Compare: MTIME=0x10. On a 32-bit port, write MTIMECMP[1] high=0 then low=0x12. With a tick every cycle, timer_irq_o[1] rises 1 cycle after mtime reaches 0x12. Rewrite cmp=0x100 -> the IRQ drops the next cycle.
- Collision/wrap: write MTIME=0xFFFF_FFFF_FFFF_FFFF with be=0xFF in the same cycle as a tick -> reads that value; the next tick -> 0.
- Errors/IPI:
  - Write MSIP[NR_HARTS] -> err_o=1 with msip_o unchanged.
  - Write MSIP[0]=1 and SSIP[0]=1 -> msip_o[0]=ssip_o[0]=1; a read returns 1 with err_o=0.

Source files
------------

// File: rtl/aclint_pkg.sv
// ----------------------------------------------------------------------------
// aclint_pkg: register map, CTRL layout and byte-merge helpers. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package aclint_pkg;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_BASE    = 16'hBFF8;
    localparam logic [15:0] SSIP_BASE     = 16'hC000;
    localparam logic [15:0] CTRL_OFF      = 16'hD000;
    localparam logic [15:0] PRESCALE_OFF  = 16'hD004;

    localparam int CTRL_SRC_BIT = 0;
    localparam int CTRL_EN_BIT  = 1;

    typedef struct packed {
        logic enable;
        logic src;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{enable: 1'b1, src: 1'b0};

    function automatic logic [63:0] be_merge64(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  be);
        logic [63:0] res;
        for (int b = 0; b < 8; b++) begin
            res[b*8 +: 8] = be[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] be_merge32(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = be[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aclint_tick_gen.sv
// ----------------------------------------------------------------------------
// aclint_tick_gen: synchronised RTC edge detector and programmable prescaler. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module aclint_tick_gen #(
    parameter int unsigned PRESCALE_W  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rtc_i,
    input  logic                  src_i,
    input  logic                  enable_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  reload_i,
    output logic                  tick_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rtc_prev_q;
    logic [PRESCALE_W-1:0]  cnt_q;
    logic                   rtc_edge;
    logic                   pre_tick;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            rtc_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rtc_i};
            rtc_prev_q <= sync_q[SYNC_STAGES-1];
            if (reload_i || (cnt_q == '0)) begin
                cnt_q <= prescale_i;
            end else begin
                cnt_q <= cnt_q - PRESCALE_W'(1);
            end
        end
    end

    assign rtc_edge = sync_q[SYNC_STAGES-1] & ~rtc_prev_q;
    // A reload restarts the period, so it swallows a coincident terminal count.
    assign pre_tick = (cnt_q == '0) && !reload_i;
    assign tick_o   = enable_i && (src_i ? pre_tick : rtc_edge);

endmodule

`default_nettype wire

// File: rtl/aclint_timer.sv
// ----------------------------------------------------------------------------
// aclint_timer: 64-bit mtime, per-hart mtimecmp/MSIP/SSIP behind a req/gnt port. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module aclint_timer
    import aclint_pkg::*;
#(
    parameter int unsigned NR_HARTS    = 1,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned PRESCALE_W  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [15:0]             addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic                    gnt_o,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    input  logic                    rtc_i,
    output logic [NR_HARTS-1:0]     timer_irq_o,
    output logic [NR_HARTS-1:0]     msip_o,
    output logic [NR_HARTS-1:0]     ssip_o
);

    localparam logic        PORT64     = (DATA_WIDTH == 64);
    localparam logic [12:0] NR_HARTS_L = 13'(NR_HARTS);

    // Internally every access is seen as a 64-bit doubleword with byte lanes.
    logic [63:0]           wdata64;
    logic [7:0]            be64;
    logic [63:0]           rdata64;
    logic [DATA_WIDTH-1:0] rdata_sel;

    if (DATA_WIDTH == 64) begin : g_port64
        assign wdata64   = 64'(wdata_i);
        assign be64      = 8'(be_i);
        assign rdata_sel = DATA_WIDTH'(rdata64);
    end else begin : g_port32
        assign wdata64   = 64'({wdata_i, wdata_i});
        assign be64      = 8'(addr_i[2] ? {be_i, 4'b0000} : {4'b0000, be_i});
        assign rdata_sel = DATA_WIDTH'(addr_i[2] ? rdata64[63:32] : rdata64[31:0]);
    end

    logic        sel_hi;
    logic [31:0] wdata32;
    logic [3:0]  be4;

    assign sel_hi  = addr_i[2];
    assign wdata32 = sel_hi ? wdata64[63:32] : wdata64[31:0];
    assign be4     = sel_hi ? be64[7:4] : be64[3:0];

    // Address decode
    logic        sel_msip, sel_cmp, sel_mtime, sel_ssip, sel_ctrl, sel_pre;
    logic [12:0] cmp_hart;
    logic [11:0] hart_idx;
    logic        is_reg64, mapped, hart_bad, bad, wr_ok;
    logic        unused_cmp_msb;

    assign sel_msip  = addr_i[15:14] == MSIP_BASE[15:14];
    assign sel_cmp   = (addr_i >= MTIMECMP_BASE) && (addr_i < MTIME_BASE);
    assign sel_mtime = addr_i[15:3] == MTIME_BASE[15:3];
    assign sel_ssip  = addr_i[15:12] == SSIP_BASE[15:12];
    assign sel_ctrl  = addr_i[15:2] == CTRL_OFF[15:2];
    assign sel_pre   = addr_i[15:2] == PRESCALE_OFF[15:2];
    assign cmp_hart  = addr_i[15:3] - MTIMECMP_BASE[15:3];
    assign unused_cmp_msb = cmp_hart[12];

    always_comb begin
        hart_idx = '0;
        is_reg64 = 1'b0;
        mapped   = 1'b1;
        if (sel_msip) begin
            hart_idx = addr_i[13:2];
        end else if (sel_cmp) begin
            hart_idx = cmp_hart[11:0];
            is_reg64 = 1'b1;
        end else if (sel_mtime) begin
            is_reg64 = 1'b1;
        end else if (sel_ssip) begin
            hart_idx = {2'b00, addr_i[11:2]};
        end else if (!(sel_ctrl || sel_pre)) begin
            mapped = 1'b0;
        end
    end

    assign hart_bad = (sel_msip || sel_cmp || sel_ssip) && ({1'b0, hart_idx} >= NR_HARTS_L);
    // A 64-bit register on a 64-bit port must sit on a doubleword boundary.
    assign bad      = !mapped || (addr_i[1:0] != 2'b00) || hart_bad
                      || (PORT64 && is_reg64 && addr_i[2]);
    assign wr_ok    = req_i && we_i && !bad;

    // Global registers
    ctrl_t                 ctrl_q, ctrl_new;
    logic [PRESCALE_W-1:0] prescale_q, prescale_next;
    logic [63:0]           mtime_q;
    logic                  wr_ctrl, wr_pre, mtime_wr, tick;

    assign wr_ctrl  = wr_ok && sel_ctrl;
    assign wr_pre   = wr_ok && sel_pre;
    assign mtime_wr = wr_ok && sel_mtime && (be64 != 8'h00);

    always_comb begin
        ctrl_new = ctrl_q;
        if (be4[0]) begin
            ctrl_new.src    = wdata32[CTRL_SRC_BIT];
            ctrl_new.enable = wdata32[CTRL_EN_BIT];
        end
        prescale_next = prescale_q;
        if (wr_pre) begin
            prescale_next = PRESCALE_W'(be_merge32(32'(prescale_q), wdata32, be4));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q     <= CTRL_RESET;
            prescale_q <= '0;
            mtime_q    <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_q <= ctrl_new;
            end
            prescale_q <= prescale_next;
            // A bus write beats a coincident tick.
            if (mtime_wr) begin
                mtime_q <= be_merge64(mtime_q, wdata64, be64);
            end else if (tick) begin
                mtime_q <= mtime_q + 64'd1;
            end
        end
    end

    aclint_tick_gen #(
        .PRESCALE_W  (PRESCALE_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tick_gen (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rtc_i      (rtc_i),
        .src_i      (ctrl_q.src),
        .enable_i   (ctrl_q.enable),
        .prescale_i (prescale_next),
        .reload_i   (wr_ctrl || wr_pre),
        .tick_o     (tick)
    );

    // Per-hart registers
    logic [63:0] cmp_arr [NR_HARTS];

    for (genvar h = 0; h < NR_HARTS; h++) begin : g_hart
        logic        hit;
        logic [63:0] cmp_q;
        logic        msip_q, ssip_q, irq_q;

        assign hit = wr_ok && (hart_idx == 12'(h));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cmp_q  <= '1;
                msip_q <= 1'b0;
                ssip_q <= 1'b0;
                irq_q  <= 1'b0;
            end else begin
                if (hit && sel_cmp) begin
                    cmp_q <= be_merge64(cmp_q, wdata64, be64);
                end
                if (hit && sel_msip && be4[0]) begin
                    msip_q <= wdata32[0];
                end
                if (hit && sel_ssip && be4[0]) begin
                    ssip_q <= wdata32[0];
                end
                irq_q <= (mtime_q >= cmp_q);
            end
        end

        assign cmp_arr[h]     = cmp_q;
        assign msip_o[h]      = msip_q;
        assign ssip_o[h]      = ssip_q;
        assign timer_irq_o[h] = irq_q;
    end

    // Read mux: 32-bit registers land in the lane chosen by addr_i[2].
    logic [31:0] rd32;
    logic [63:0] rd64;

    always_comb begin
        rd32 = '0;
        rd64 = '0;
        for (int h = 0; h < NR_HARTS; h++) begin
            if (hart_idx == 12'(h)) begin
                if (sel_cmp)  rd64 = cmp_arr[h];
                if (sel_msip) rd32 = {31'b0, msip_o[h]};
                if (sel_ssip) rd32 = {31'b0, ssip_o[h]};
            end
        end
        if (sel_mtime) rd64 = mtime_q;
        if (sel_ctrl) begin
            rd32[CTRL_SRC_BIT] = ctrl_q.src;
            rd32[CTRL_EN_BIT]  = ctrl_q.enable;
        end
        if (sel_pre) rd32 = 32'(prescale_q);
        rdata64 = is_reg64 ? rd64 : (sel_hi ? {rd32, 32'b0} : {32'b0, rd32});
    end

    // Response stage
    logic                  rvalid_q, err_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= req_i;
            err_q    <= req_i && bad;
            rdata_q  <= (req_i && !we_i && !bad) ? rdata_sel : '0;
        end
    end

    assign gnt_o    = req_i;
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_aclint_timer.sv
// ----------------------------------------------------------------------------
// tb_aclint_timer: directed self-checking bench, 32-bit port, two harts. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_aclint_timer;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;
    logic        rtc = 1'b0;
    logic [1:0]  timer_irq, msip, ssip;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aclint_timer #(
        .NR_HARTS    (2),
        .DATA_WIDTH  (32),
        .PRESCALE_W  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_i       (req),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .be_i        (be),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .err_o       (err),
        .rtc_i       (rtc),
        .timer_irq_o (timer_irq),
        .msip_o      (msip),
        .ssip_o      (ssip)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%h expected=0x%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the response sampled.
    task automatic bus(input logic wr, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] b, output logic [31:0] rd, output logic er);
        req = 1'b1; we = wr; addr = a; wdata = d; be = b;
        #1;
        check_eq("gnt", 64'(gnt), 64'd1);
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        check_eq("rvalid", 64'(rvalid), 64'd1);
        rd = rdata;
        er = err;
    endtask

    task automatic wr32(input logic [15:0] a, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] rd;
        logic        er;
        bus(1'b1, a, d, b, rd, er);
        check_eq("wr_err", 64'(er), 64'd0);
        check_eq("wr_rdata", 64'(rd), 64'd0);
    endtask

    task automatic rd32(input logic [15:0] a, output logic [31:0] rd);
        logic er;
        bus(1'b0, a, 32'h0, 4'h0, rd, er);
        check_eq("rd_err", 64'(er), 64'd0);
    endtask

    task automatic rd64(input logic [15:0] a, output logic [63:0] v);
        logic [31:0] lo, hi;
        rd32(a, lo);
        rd32(a + 16'd4, hi);
        v = {hi, lo};
    endtask

    initial begin
        logic [31:0] r, base, m1;
        logic [63:0] v;
        logic        er;

        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r, base, m1;
        logic [63:0] v;
        logic        er;

        repeat (3) @(negedge clk);
        rst_ni = 1'b1;

        // Reset state
        check_eq("rst_outs", 64'({rvalid, err, timer_irq, msip, ssip}), 64'd0);
        check_eq("rst_rdata", 64'(rdata), 64'd0);
        rd64(16'h4000, v);
        check_eq("rst_cmp0", v, 64'hFFFF_FFFF_FFFF_FFFF);
        rd32(16'hD000, r);
        check_eq("rst_ctrl", 64'(r), 64'h2);
        repeat (10) @(negedge clk);
        check_eq("idle_rvalid", 64'(rvalid), 64'd0);
        rd64(16'hBFF8, v);
        check_eq("rst_mtime", v, 64'd0);
        check_eq("rst_irq", 64'(timer_irq), 64'd0);

        // RTC mode: five edges, then a long high level gives one more
        for (int i = 0; i < 5; i++) begin
            rtc = 1'b1; repeat (4) @(negedge clk);
            rtc = 1'b0; repeat (4) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        rd32(16'hBFF8, r);
        check_eq("rtc_5", 64'(r), 64'd5);
        rtc = 1'b1; repeat (20) @(negedge clk);
        rtc = 1'b0; repeat (5) @(negedge clk);
        rd32(16'hBFF8, r);
        check_eq("rtc_level", 64'(r), 64'd6);

        // Prescaler mode: period PRESCALE+1 = 4 cycles
        wr32(16'hD004, 32'd3, 4'hF);
        rd32(16'hBFF8, base);
        wr32(16'hD000, 32'h3, 4'hF);
        repeat (40) @(negedge clk);
        rd32(16'hBFF8, r);
        r = r - base;
        check_eq("pre_ticks", (r >= 9 && r <= 11) ? 64'd10 : 64'(r), 64'd10);
        wr32(16'hD000, 32'h1, 4'hF);
        rd32(16'hBFF8, m1);
        repeat (20) @(negedge clk);
        rd32(16'hBFF8, r);
        check_eq("disabled_frozen", 64'(r), 64'(m1));

        // Compare on hart 1 with a tick every cycle
        wr32(16'hD004, 32'd0, 4'hF);
        wr32(16'hBFF8, 32'h10, 4'hF);
        wr32(16'hBFFC, 32'h0, 4'hF);
        wr32(16'h400C, 32'h0, 4'hF);
        wr32(16'h4008, 32'h12, 4'hF);
        check_eq("cmp_pre_irq", 64'(timer_irq), 64'd0);
        wr32(16'hD000, 32'h3, 4'hF);
        repeat (2) @(negedge clk);
        check_eq("irq_at_reach", 64'(timer_irq), 64'b00);
        @(negedge clk);
        check_eq("irq_rise", 64'(timer_irq), 64'b10);
        wr32(16'h4008, 32'h100, 4'hF);
        check_eq("irq_hold", 64'(timer_irq), 64'b10);
        @(negedge clk);
        check_eq("irq_drop", 64'(timer_irq), 64'b00);

        // Write beats tick, then wrap to zero
        wr32(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        wr32(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
        rd32(16'hBFF8, r);
        check_eq("collide_lo", 64'(r), 64'hFFFF_FFFF);
        rd32(16'hBFFC, r);
        check_eq("wrap_hi", 64'(r), 64'd0);
        rd32(16'hBFF8, r);
        check_eq("wrap_lo", 64'(r), 64'd1);
        wr32(16'hD000, 32'h1, 4'hF);

        // Byte enables and unused bits
        wr32(16'hD004, 32'h1234_5678, 4'b0010);
        rd32(16'hD004, r);
        check_eq("pre_be", 64'(r), 64'h5600);
        wr32(16'hD004, 32'hFFFF_FFFF, 4'hF);
        rd32(16'hD004, r);
        check_eq("pre_width", 64'(r), 64'hFFFF);

        // Errors and software interrupts
        bus(1'b1, 16'h0008, 32'h1, 4'hF, r, er);
        check_eq("err_hart", 64'(er), 64'd1);
        check_eq("err_msip_kept", 64'(msip), 64'd0);
        bus(1'b0, 16'h4002, 32'h0, 4'h0, r, er);
        check_eq("err_misalign", 64'({er, r}), 64'h1_0000_0000);
        bus(1'b0, 16'hE000, 32'h0, 4'h0, r, er);
        check_eq("err_unmapped", 64'(er), 64'd1);
        wr32(16'h0000, 32'h1, 4'hF);
        wr32(16'hC000, 32'h1, 4'hF);
        check_eq("msip_out", 64'(msip), 64'b01);
        check_eq("ssip_out", 64'(ssip), 64'b01);
        rd32(16'h0000, r);
        check_eq("msip_rd", 64'(r), 64'd1);
        rd32(16'hC000, r);
        check_eq("ssip_rd", 64'(r), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
